// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode encoding, default
// datapath width and arbiter state constants.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b1101,
    OP_SRA = 4'b0111,
    OP_SLT = 4'b1100,
    OP_EQ  = 4'b1000
  } alu_op_e;

  // Arbiter state names describe which port wins the next tie.
  localparam logic [0:0] IDLE_PREF0 = 1'b0;
  localparam logic [0:0] IDLE_PREF1 = 1'b1;

  function automatic logic is_supported(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL,
      OP_SRL, OP_SRA, OP_SLT, OP_EQ: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared ALU.
interface alu_share_arbiter_if #(parameter int WIDTH = alu_pkg::DEFAULT_WIDTH);

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][3:0]       req_op;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [1:0][WIDTH-1:0] rsp_result;
  logic [1:0]            rsp_zero;
  logic [1:0]            rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational ALU; unsupported opcodes yield zero with err set.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign err  = !is_supported(op);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// one-entry registered response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 2
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [0:0]                 state;
  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            grant;
  logic                       sel;
  logic [WIDTH-1:0]           alu_result;
  logic                       alu_zero;
  logic                       alu_err;
  logic [NREQ-1:0]            valid_q;
  logic [NREQ-1:0][WIDTH-1:0] result_q;
  logic [NREQ-1:0]            zero_q;
  logic [NREQ-1:0]            err_q;

  // A port may issue when its slot is empty or being drained this cycle.
  assign eligible = bus.req_valid & (~valid_q | bus.rsp_ready);

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11)
      grant = (state == IDLE_PREF0) ? 2'b01 : 2'b10;
  end

  assign bus.req_ready = rst_n ? grant : 2'b00;
  assign sel           = grant[1];

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (bus.req_op[sel]),
    .a      (bus.req_a[sel]),
    .b      (bus.req_b[sel]),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE_PREF0;
    else if (grant[0])
      state <= IDLE_PREF1;
    else if (grant[1])
      state <= IDLE_PREF0;
  end

  // A new grant overwrites the slot, so pop-and-reissue never bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      result_q <= '0;
      zero_q   <= '0;
      err_q    <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          valid_q[i]  <= 1'b1;
          result_q[i] <= alu_result;
          zero_q[i]   <= alu_zero;
          err_q[i]    <= alu_err;
        end else if (valid_q[i] && bus.rsp_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

endmodule
